// File: rtl/axi_stream_skid_buffer.sv
// axi_stream_skid_buffer
// Two-entry AXI4-Stream register slice. Every forward signal and s_tready
// come straight from flops, so no input reaches any output combinationally.
// OUT always holds the older beat; SKID catches the one beat that arrives in
// the cycle the sink stalls. Full throughput is kept while m_tready is high.

module axi_stream_skid_buffer #(
  parameter int byte_width  = 4,
  parameter int id_width    = 1,
  parameter int dest_width  = 1,
  parameter int user_width  = 1,
  parameter int count_width = 32
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [8*byte_width-1:0]   s_tdata,
  input  logic [byte_width-1:0]     s_tstrb,
  input  logic [byte_width-1:0]     s_tkeep,
  input  logic                      s_tlast,
  input  logic [id_width-1:0]       s_tid,
  input  logic [dest_width-1:0]     s_tdest,
  input  logic [user_width-1:0]     s_tuser,

  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [8*byte_width-1:0]   m_tdata,
  output logic [byte_width-1:0]     m_tstrb,
  output logic [byte_width-1:0]     m_tkeep,
  output logic                      m_tlast,
  output logic [id_width-1:0]       m_tid,
  output logic [dest_width-1:0]     m_tdest,
  output logic [user_width-1:0]     m_tuser,

  output logic [1:0]                occupancy,
  output logic [count_width-1:0]    pkt_count
);

  // All payload fields travel together as one packed word.
  localparam int data_width = 8 * byte_width;
  localparam int pay_width  = data_width + 2 * byte_width + 1
                              + id_width + dest_width + user_width;

  // Encoding matches the number of beats held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;

  logic                   s_tready_q, s_tready_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [1:0]             occupancy_q, occupancy_d;
  logic [count_width-1:0] pkt_count_q, pkt_count_d;

  logic [pay_width-1:0]   s_pay;
  logic [pay_width-1:0]   out_q, out_d;
  logic [pay_width-1:0]   skid_q, skid_d;

  logic                   s_xfer;
  logic                   m_xfer;
  logic                   load_out_from_s;
  logic                   load_out_from_skid;
  logic                   load_skid;

  // ---------------------------------------------------------------------------
  // Handshake events and payload packing
  // ---------------------------------------------------------------------------
  assign s_pay  = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
  assign s_xfer = s_tvalid && s_tready_q;
  assign m_xfer = m_tvalid_q && m_tready;

  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_q;

  assign s_tready  = s_tready_q;
  assign m_tvalid  = m_tvalid_q;
  assign occupancy = occupancy_q;
  assign pkt_count = pkt_count_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register; reset discards whatever was buffered.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: track how many beats are held after this edge's handshakes.
  always_comb begin
    // NOTE: defaulting to the current value first keeps this combinational
    // block from inferring a latch on any unlisted path.
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (s_xfer) state_d = ONE;
      end
      ONE: begin
        if (s_xfer && !m_xfer)      state_d = FULL;
        else if (!s_xfer && m_xfer) state_d = EMPTY;
      end
      FULL: begin
        if (m_xfer) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs: datapath load selects plus next values of the registered flags.
  always_comb begin
    load_out_from_s    = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    unique case (state_q)
      EMPTY: begin
        load_out_from_s = s_xfer;
      end
      ONE: begin
        // A beat arriving while OUT leaves replaces OUT directly; otherwise
        // it must wait behind OUT in SKID to preserve order.
        load_out_from_s = s_xfer && m_xfer;
        load_skid       = s_xfer && !m_xfer;
      end
      FULL: begin
        load_out_from_skid = m_xfer;
      end
      default: begin
        load_out_from_s    = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
      end
    endcase

    // Flags are registered from the next state so they line up with it.
    s_tready_d  = (state_d != FULL);
    m_tvalid_d  = (state_d != EMPTY);
    occupancy_d = state_d;
  end

  // Handshake flags and occupancy; s_tready stays low through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_tready_q  <= 1'b0;
      m_tvalid_q  <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      s_tready_q  <= s_tready_d;
      m_tvalid_q  <= m_tvalid_d;
      occupancy_q <= occupancy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers
  // ---------------------------------------------------------------------------

  // Select next OUT/SKID contents; both hold when not loaded.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (load_out_from_s) begin
      out_d = s_pay;
    end else if (load_out_from_skid) begin
      out_d = skid_q;
    end
    if (load_skid) begin
      skid_d = s_pay;
    end
  end

  // OUT and SKID storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is cleared on reset only to keep simulation free of X;
    // m_tvalid already qualifies it, so this reset is not functionally needed.
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet counter
  // ---------------------------------------------------------------------------

  // Count end-of-packet beats leaving the master port; wraps naturally.
  always_comb begin
    pkt_count_d = pkt_count_q;
    if (m_xfer && m_tlast) begin
      pkt_count_d = pkt_count_q + count_width'(1);
    end
  end

  // Counter register; reset wins over a coincident last-beat transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_skid_buffer.sv
// Scoreboard bench for axi_stream_skid_buffer: accepted upstream beats are
// queued, a negedge monitor pops and compares each beat the master port
// emits, and directed checks cover reset, streaming, stall, drain, mid-stream
// reset and counter wrap with hand-computed values.

module tb_axi_stream_skid_buffer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  id;
    logic [1:0]  dest;
    logic [1:0]  user;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        s_tvalid, s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb, s_tkeep;
  logic        s_tlast;
  logic [1:0]  s_tid, s_tdest, s_tuser;
  logic        m_tvalid, m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb, m_tkeep;
  logic        m_tlast;
  logic [1:0]  m_tid, m_tdest, m_tuser;
  logic [1:0]  occupancy;
  logic [1:0]  pkt_count;

  int n_vec  = 0;
  int n_miss = 0;

  beat_t exp_q[$];
  logic  stall_prev = 1'b0;
  beat_t stall_pay;

  axi_stream_skid_buffer #(
    .byte_width (4),
    .id_width   (2),
    .dest_width (2),
    .user_width (2),
    .count_width(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tstrb  (s_tstrb),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tid    (s_tid),
    .s_tdest  (s_tdest),
    .s_tuser  (s_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tstrb  (m_tstrb),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tdest  (m_tdest),
    .m_tuser  (m_tuser),
    .occupancy(occupancy),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.strb = d[7:4];
    b.keep = d[3:0];
    b.last = l;
    b.id   = d[1:0];
    b.dest = d[3:2];
    b.user = d[5:4];
    return b;
  endfunction

  function automatic beat_t rand_beat();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[46:0];
  endfunction

  task automatic drive(input logic v, input beat_t b);
    s_tvalid = v;
    s_tdata  = b.data;
    s_tstrb  = b.strb;
    s_tkeep  = b.keep;
    s_tlast  = b.last;
    s_tid    = b.id;
    s_tdest  = b.dest;
    s_tuser  = b.user;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: model occupancy, check held-output stability, pop/compare
  // emitted beats, then record newly accepted beats.
  always @(negedge clk) begin
    beat_t cur;
    beat_t exp_b;
    cur = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("occ_model", 64'(occupancy), 64'(exp_q.size()));
      check("valid_model", 64'(m_tvalid), 64'(exp_q.size() != 0));
      if (stall_prev) begin
        check("stall_valid_hold", 64'(m_tvalid), 64'(1));
        check("stall_payload_hold", 64'(cur), 64'(stall_pay));
      end
      if (m_tvalid && m_tready) begin
        check("sb_underflow", 64'(exp_q.size() == 0), 64'(0));
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("sb_beat", 64'(cur), 64'(exp_b));
        end
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back({s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser});
      end
      stall_prev = m_tvalid && !m_tready;
      stall_pay  = cur;
    end
  end

  logic [1:0] wrap_exp [5];
  logic       xfer;

  initial begin
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset
    reset    = 1'b1;
    m_tready = 1'b0;
    drive(1'b0, mk(32'h0, 1'b0));
    repeat (2) tick();
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    reset = 1'b0;
    tick();
    check("rel_s_tready", 64'(s_tready), 64'(1));
    check("rel_m_tvalid", 64'(m_tvalid), 64'(0));

    // Streaming: 8 beats, one cycle behind input
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(32'(i), i == 7));
      tick();
      check("stream_data", 64'(m_tdata), 64'(i));
      check("stream_valid", 64'(m_tvalid), 64'(1));
      check("stream_occ", 64'(occupancy), 64'(1));
    end
    s_tvalid = 1'b0;
    tick();
    check("stream_end_valid", 64'(m_tvalid), 64'(0));
    check("stream_pkt_count", 64'(pkt_count), 64'(1));

    // Stall fill: A, B accepted, C held upstream
    m_tready = 1'b0;
    drive(1'b1, mk(32'hA0A0_0001, 1'b0));
    tick();
    check("fill_a_data", 64'(m_tdata), 64'h0000_0000_A0A0_0001);
    check("fill_a_ready", 64'(s_tready), 64'(1));
    check("fill_a_occ", 64'(occupancy), 64'(1));
    drive(1'b1, mk(32'hB0B0_0002, 1'b0));
    tick();
    check("fill_b_ready", 64'(s_tready), 64'(0));
    check("fill_b_occ", 64'(occupancy), 64'(2));
    check("fill_b_data", 64'(m_tdata), 64'h0000_0000_A0A0_0001);
    drive(1'b1, mk(32'hC0C0_0003, 1'b0));
    tick();
    check("fill_c_ready", 64'(s_tready), 64'(0));
    check("fill_c_occ", 64'(occupancy), 64'(2));
    check("fill_c_data", 64'(m_tdata), 64'h0000_0000_A0A0_0001);

    // Drain: A, B, C leave back to back
    m_tready = 1'b1;
    tick();
    check("drain_b_data", 64'(m_tdata), 64'h0000_0000_B0B0_0002);
    check("drain_b_ready", 64'(s_tready), 64'(1));
    check("drain_b_occ", 64'(occupancy), 64'(1));
    tick();
    check("drain_c_data", 64'(m_tdata), 64'h0000_0000_C0C0_0003);
    check("drain_c_valid", 64'(m_tvalid), 64'(1));
    s_tvalid = 1'b0;
    tick();
    check("drain_end_valid", 64'(m_tvalid), 64'(0));
    check("drain_pkt_count", 64'(pkt_count), 64'(1));

    // Reset while FULL
    m_tready = 1'b0;
    drive(1'b1, mk(32'h1111_1111, 1'b1));
    tick();
    drive(1'b1, mk(32'h2222_2222, 1'b1));
    tick();
    s_tvalid = 1'b0;
    check("pre_rst_occ", 64'(occupancy), 64'(2));
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 64'(m_tvalid), 64'(0));
    check("mid_rst_ready", 64'(s_tready), 64'(0));
    check("mid_rst_occ", 64'(occupancy), 64'(0));
    check("mid_rst_pkt", 64'(pkt_count), 64'(0));
    reset = 1'b0;
    tick();
    check("post_rst_ready", 64'(s_tready), 64'(1));
    m_tready = 1'b1;
    drive(1'b1, mk(32'h55, 1'b0));
    tick();
    check("post_rst_data", 64'(m_tdata), 64'h55);
    check("post_rst_valid", 64'(m_tvalid), 64'(1));
    s_tvalid = 1'b0;
    tick();
    check("post_rst_drained", 64'(m_tvalid), 64'(0));

    // Counter wrap with 2-bit counter
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, mk(32'h100 + 32'(k), 1'b1));
      tick();
      s_tvalid = 1'b0;
      tick();
      check("wrap_pkt_count", 64'(pkt_count), 64'(wrap_exp[k]));
    end

    // Reset coincident with a last-beat m-transfer: reset wins
    drive(1'b1, mk(32'h77, 1'b1));
    tick();
    s_tvalid = 1'b0;
    reset    = 1'b1;
    tick();
    check("rst_vs_xfer_pkt", 64'(pkt_count), 64'(0));
    check("rst_vs_xfer_valid", 64'(m_tvalid), 64'(0));
    reset = 1'b0;
    tick();

    // Random handshakes; source holds a beat until it is accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      xfer = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (!s_tvalid || xfer) begin
        if ($urandom_range(0, 3) != 0) drive(1'b1, rand_beat());
        else s_tvalid = 1'b0;
      end
      m_tready = ($urandom_range(0, 1) != 0);
    end

    // Drain everything and confirm nothing is left
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (4) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    check("final_valid", 64'(m_tvalid), 64'(0));
    check("final_occ", 64'(occupancy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
